// File: rtl/wb_grf.sv
// MIPS write-back stage: MEM/WB register, load extension, 32x32 GRF with write-to-read forwarding.
// Latency: MEM values reach the WB outputs one edge after capture; the GRF write lands on the next edge.
// No backpressure. Define GRF_TRACE_EN to print one trace line per GRF write.
module wb_grf #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_MEM,
    input  logic [4:0]  regWriteAddr_MEM,
    input  logic [31:0] regWriteData_MEM,
    input  logic [2:0]  ldType_MEM,
    input  logic [31:0] memRdata_MEM,
    input  logic [1:0]  memAddrLow_MEM,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [4:0]  regaddr_WB,
    output logic [31:0] regdata_WB,
    output logic [31:0] PC_WB
);

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LB  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd3;
    localparam logic [2:0] LD_LH  = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    logic [31:0] pc_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [2:0]  ld_type_q;
    logic [31:0] rdata_q;
    logic [1:0]  low_q;

    logic [31:0] grf [0:31];

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= PC_RESET;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ld_type_q <= '0;
            rdata_q   <= '0;
            low_q     <= '0;
        end else begin
            pc_q      <= PC_MEM;
            waddr_q   <= regWriteAddr_MEM;
            wdata_q   <= regWriteData_MEM;
            ld_type_q <= ldType_MEM;
            rdata_q   <= memRdata_MEM;
            low_q     <= memAddrLow_MEM;
        end
    end

    always_comb begin
        ld_byte = rdata_q[7:0];
        case (low_q)
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            2'd3:    ld_byte = rdata_q[31:24];
            default: ld_byte = rdata_q[7:0];
        endcase
        // Halfword select uses only bit 1; an odd offset is the MEM stage's problem.
        ld_half = low_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    always_comb begin
        wb_data = wdata_q;
        case (ld_type_q)
            LD_LW:   wb_data = rdata_q;
            LD_LB:   wb_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  wb_data = {24'd0, ld_byte};
            LD_LH:   wb_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  wb_data = {16'd0, ld_half};
            default: wb_data = wdata_q;
        endcase
    end

    assign regaddr_WB = waddr_q;
    assign regdata_WB = wb_data;
    assign PC_WB      = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                grf[i] <= '0;
            end
        end else if (waddr_q != 5'd0) begin
            grf[waddr_q] <= wb_data;
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && waddr_q != 5'd0) begin
            $display("%d@%h: $%d <= %h", $time, pc_q, waddr_q, wb_data);
        end
    end
`endif

    // Inner forward: a reader of the register being written this cycle sees the new value.
    always_comb begin
        if (RA1 == 5'd0)
            RD1 = '0;
        else if (RA1 == waddr_q)
            RD1 = wb_data;
        else
            RD1 = grf[RA1];

        if (RA2 == 5'd0)
            RD2 = '0;
        else if (RA2 == waddr_q)
            RD2 = wb_data;
        else
            RD2 = grf[RA2];
    end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage and general register file for the 5-stage MIPS pipeline.
- Holds the MEM/WB pipeline register and sign- or zero-extends load data.
- Writes the selected result into a 32x32 GRF.
- Serves the two combinational GRF read ports that the decode stage drives (RA1/RA2 -> RD1/RD2), with write-to-read inner forwarding. Decode therefore never forwards from WB explicitly.

Parameters:
- PC_RESET, 32'h0000_3000, reset value of PC_WB.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- PC_MEM  in  32  PC of the instruction leaving MEM
- regWriteAddr_MEM  in  5  destination register; 0 = no write
- regWriteData_MEM  in  32  non-load result (ALU, link, HI/LO, LUI)
- ldType_MEM  in  3  0 none, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU; 6/7 treated as 0
- memRdata_MEM  in  32  raw DM read word
- memAddrLow_MEM  in  2  byte offset of the load address
- RA1  in  5  read address 1 (rs)
- RA2  in  5  read address 2 (rt)
- RD1  out  32  read data 1
- RD2  out  32  read data 2
- regaddr_WB  out  5  WB destination, for the hazard unit and forwarding
- regdata_WB  out  32  final WB write data
- PC_WB  out  32  PC in WB

Behaviour:
- Reset (posedge clk, reset=1):
  - All pipeline registers clear to 0, except PC_WB, which loads PC_RESET.
  - All 32 GRF entries clear to 0.
  - Reset has priority over the same-edge write.
- Pipeline register: on every non-reset posedge it captures PC, regWriteAddr, regWriteData, ldType, memRdata and memAddrLow from MEM. There is no stall or clear input; bubbles arrive with regWriteAddr_MEM=0.
- Latency: MEM values appear on the WB outputs 1 cycle after the capturing edge. The GRF write occurs at the following edge.
- Load extension (combinational, on registered values; b = byte offset, h = low[1]):
  - LW: whole word. Low bits are ignored; alignment is the MEM stage's responsibility.
  - LB: sign-extend byte b = rdata[8b+7:8b].
  - LBU: zero-extend the same byte.
  - LH: sign-extend half h = rdata[16h+15:16h]; low[0] is ignored.
  - LHU: zero-extend the same half.
- regdata_WB: the extended load data when ldType is 1..5, otherwise the registered regWriteData.
- regaddr_WB: the registered regWriteAddr.
- GRF write: at posedge, if !reset and regaddr_WB != 0, then GRF[regaddr_WB] <= regdata_WB.
  - $0 is never written and always reads 0.
- Read port n, combinational:
  - RAn == 0 -> 0.
  - Else if RAn == regaddr_WB (nonzero) -> regdata_WB (inner forward).
  - Else -> GRF[RAn].
- Both ports may address the same register, including the forwarded one; both return identical data.
- Back-to-back writes to the same register: the later one wins, and each is visible via forwarding during its own WB cycle.
- Reset asserted mid-stream: the in-flight WB write is dropped. The instruction captured on the reset edge is lost, because its pipeline register is cleared.

Optional Feature:
- GRF_TRACE_EN defined:
  - At each posedge where a GRF write occurs (!reset, regaddr_WB != 0), the block prints one line: "%d@%h: $%d <= %h" with $time, PC_WB, regaddr_WB, regdata_WB.
  - Writes to $0 and cycles under reset print nothing.
- GRF_TRACE_EN undefined: no $display is present and the block is synthesis-clean. Functional behaviour is identical in both cases.

Test Plan:
- Reset check: hold reset 2 cycles. Expect PC_WB=0x00003000, regaddr_WB=0, and RD1/RD2=0 for every RA.
- Plain write: MEM addr=8, data=0x12345678, ldType=0, PC=0x3004. Next cycle: regdata_WB=0x12345678, and RA1=8 returns 0x12345678 via forward. After the following edge, RA2=8 returns 0x12345678 from the array.
- Load extension, rdata=0x80FF7F01:
  - LB b=3 -> 0xFFFFFF80.
  - LBU b=2 -> 0x000000FF.
  - LB b=0 -> 0x00000001.
  - LH h=1 -> 0xFFFF80FF.
  - LHU h=0 -> 0x00007F01.
  - LW b=2 -> 0x80FF7F01.
  - ldType=6 with regWriteData=0xA5 -> 0xA5.
- $0 protection: write addr=0, data=0xDEADBEEF. RA1=RA2=0 returns 0, no GRF change, and no trace line when GRF_TRACE_EN is defined.
- Same-register sequence: write $5=1 then $5=2 on consecutive cycles while RA1=RA2=5. Reads are 1 then 2 (forwarded), and the final array value is 2.
- Reset mid-operation: write $9=0x55 and settle it. Present addr=9, data=0x66, and assert reset at the capture edge. After reset, $9 reads 0 and no write of 0x66 occurs.
